// File: rtl/ram_sampler_n.sv
// pSRAM bus front end: synchronises the raw bus, detects glitch-filtered ram_clk edges
// and majority-votes TAPS spaced samples of every bus bit into one filtered word per edge.
`timescale 1ns/1ps
module ram_sampler_n #(
  parameter int A_WIDTH     = 23,
  parameter int D_WIDTH     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CLK_STABLE  = 2,
  parameter int TAPS        = 3,
  parameter int TAP_SPACING = 1,
  parameter int CNT_W       = 16
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               enable,
  input  logic               edge_sel,
  input  logic [A_WIDTH-1:0] ram_a,
  input  logic [D_WIDTH-1:0] ram_d,
  input  logic               ram_oe,
  input  logic               ram_we,
  input  logic               ram_ce1,
  input  logic               ram_ub,
  input  logic               ram_lb,
  input  logic               ram_adv,
  input  logic               ram_ce2,
  input  logic               ram_clk,
  output logic [A_WIDTH-1:0] filter_a,
  output logic [D_WIDTH-1:0] filter_d,
  output logic [1:0]         filter_ublb,
  output logic               filter_read,
  output logic               filter_write,
  output logic               filter_addr_latch,
  output logic               filter_strobe,
  output logic               filter_overrun,
  output logic [CNT_W-1:0]   capture_count,
  output logic               dbg_state_o
);

  localparam int W         = A_WIDTH + D_WIDTH + 5;
  localparam int BUS_DEPTH = SYNC_STAGES + CLK_STABLE - 1;
  localparam int CLK_DEPTH = SYNC_STAGES + CLK_STABLE;
  localparam int IW        = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int SW        = (TAP_SPACING > 1) ? $clog2(TAP_SPACING) : 1;

  typedef enum logic {IDLE, SAMPLE} state_t;

  state_t                  state_q, state_d;
  logic [BUS_DEPTH-1:0][W-1:0] bus_pipe_q;
  logic [CLK_DEPTH-1:0]    clk_pipe_q;
  logic [TAPS-1:0][W-1:0]  taps_q, taps_d, vote_in;
  logic [IW-1:0]           tap_idx_q, tap_idx_d;
  logic [SW-1:0]           sp_cnt_q, sp_cnt_d;
  logic [W-1:0]            filt_q, filt_d;
  logic                    strobe_q, strobe_d;
  logic                    overrun_q, overrun_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic                    chip_en;
  logic [W-1:0]            bus_raw;
  logic [W-1:0]            bus_tap;
  logic [CLK_STABLE:0]     clk_lvl;
  logic                    edge_det;

  // Controls are decoded before synchronisation so every field rides the same pipeline.
  assign chip_en = ~ram_ce1 & ram_ce2;
  assign bus_raw = {ram_a, ram_d, ~ram_ub, ~ram_lb,
                    chip_en & ~ram_oe, chip_en & ~ram_we, chip_en & ~ram_adv};

  // The bus lags the clock history so the tap lines up with the first sample at the new level.
  assign bus_tap  = bus_pipe_q[BUS_DEPTH-1];
  assign clk_lvl  = clk_pipe_q[CLK_DEPTH-1:SYNC_STAGES-1] ^ {(CLK_STABLE+1){edge_sel}};
  assign edge_det = ~clk_lvl[CLK_STABLE] & (&clk_lvl[CLK_STABLE-1:0]);

  function automatic logic [W-1:0] vote(input logic [TAPS-1:0][W-1:0] t);
    logic [W-1:0] v;
    int           ones;
    v = '0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int k = 0; k < TAPS; k++) ones = ones + int'(t[k][b]);
      v[b] = (ones >= (TAPS + 1) / 2);
    end
    return v;
  endfunction

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      bus_pipe_q <= '0;
      clk_pipe_q <= '0;
    end else begin
      bus_pipe_q[0] <= bus_raw;
      for (int i = 1; i < BUS_DEPTH; i++) bus_pipe_q[i] <= bus_pipe_q[i-1];
      clk_pipe_q <= {clk_pipe_q[CLK_DEPTH-2:0], ram_clk};
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      taps_q    <= '0;
      tap_idx_q <= '0;
      sp_cnt_q  <= '0;
      filt_q    <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      taps_q    <= taps_d;
      tap_idx_q <= tap_idx_d;
      sp_cnt_q  <= sp_cnt_d;
      filt_q    <= filt_d;
      strobe_q  <= strobe_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    tap_idx_d = tap_idx_q;
    sp_cnt_d  = sp_cnt_q;
    filt_d    = filt_q;
    strobe_d  = 1'b0;
    overrun_d = 1'b0;
    count_d   = count_q;
    // The final tap is voted straight from the pipeline, never stored.
    vote_in          = taps_q;
    vote_in[TAPS-1]  = bus_tap;
    case (state_q)
      IDLE: begin
        if (edge_det && enable) begin
          if (TAPS == 1) begin
            filt_d   = bus_tap;
            strobe_d = 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            taps_d[0] = bus_tap;
            tap_idx_d = IW'(1);
            sp_cnt_d  = SW'(TAP_SPACING - 1);
            state_d   = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        // An edge during a capture is reported and dropped; the capture carries on.
        overrun_d = edge_det && enable;
        if (sp_cnt_q != '0) begin
          sp_cnt_d = sp_cnt_q - 1'b1;
        end else if (tap_idx_q == IW'(TAPS - 1)) begin
          filt_d    = vote(vote_in);
          strobe_d  = 1'b1;
          count_d   = count_q + 1'b1;
          tap_idx_d = '0;
          state_d   = IDLE;
        end else begin
          taps_d[tap_idx_q] = bus_tap;
          tap_idx_d         = tap_idx_q + 1'b1;
          sp_cnt_d          = SW'(TAP_SPACING - 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign filter_a          = filt_q[W-1 -: A_WIDTH];
  assign filter_d          = filt_q[D_WIDTH+4 -: D_WIDTH];
  assign filter_ublb       = filt_q[4:3];
  assign filter_read       = filt_q[2];
  assign filter_write      = filt_q[1];
  assign filter_addr_latch = filt_q[0];
  assign filter_strobe     = strobe_q;
  assign filter_overrun    = overrun_q;
  assign capture_count     = count_q;
  assign dbg_state_o       = (state_q == SAMPLE);

endmodule
